enemy_vector_renderer: RTL and testbench

Consumer side of the game-logic enemy interface. Once per frame it snapshots spawn_enemyN, xenemyN and adr_enemyN for the three enemies. For each spawned enemy it walks that enemy's sprite point list in the external image ROM, offsets every point by the enemy position, and streams absolute beam points to the vector DAC driver over a valid/ready handshake. It sits between game_logic_top and the DAC output stage.

---
 rtl/enemy_vector_renderer.sv | 196 +++++++++++++++++++
 tb/tb_enemy_vector_renderer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_vector_renderer.sv
`default_nettype none
// ============================================================================
// Module   : enemy_vector_renderer
// Purpose  : Once per frame, snapshots the three enemy descriptors from the
//            game logic. For each spawned enemy it walks the sprite point list
//            in the image ROM. Each point is offset by the enemy origin, and
//            the absolute beam points are streamed to the vector DAC driver
//            over a valid/ready handshake.
// Ports    : clk, rst_n (sync, active low), frame_start (pass trigger)
//            spawn_enemyN / xenemyN / adr_enemyN   enemy descriptors (N=1..3)
//            rom_adr -> / rom_data <-               synchronous image ROM
//            pt_x, pt_y, pt_beam, pt_valid -> / pt_ready <-  point stream
//            busy, frame_done                       pass status
// Revision : 1.0  initial release
// ============================================================================
module enemy_vector_renderer #(
  parameter int                   DAC_WIDTH    = 8,
  parameter int                   ADDRESSWIDTH = 16,
  parameter logic [DAC_WIDTH-1:0] Y_ENEMY1     = 8'd200,
  parameter logic [DAC_WIDTH-1:0] Y_ENEMY2     = 8'd150,
  parameter logic [DAC_WIDTH-1:0] Y_ENEMY3     = 8'd100,
  parameter int                   MAX_PTS      = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     spawn_enemy1,
  input  logic                     spawn_enemy2,
  input  logic                     spawn_enemy3,
  input  logic [DAC_WIDTH-1:0]     xenemy1,
  input  logic [DAC_WIDTH-1:0]     xenemy2,
  input  logic [DAC_WIDTH-1:0]     xenemy3,
  input  logic [ADDRESSWIDTH-1:0]  adr_enemy1,
  input  logic [ADDRESSWIDTH-1:0]  adr_enemy2,
  input  logic [ADDRESSWIDTH-1:0]  adr_enemy3,
  output logic [ADDRESSWIDTH-1:0]  rom_adr,
  input  logic [2*DAC_WIDTH+1:0]   rom_data,
  output logic [DAC_WIDTH-1:0]     pt_x,
  output logic [DAC_WIDTH-1:0]     pt_y,
  output logic                     pt_beam,
  output logic                     pt_valid,
  input  logic                     pt_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int                 c_CNT_W    = (MAX_PTS > 1) ? $clog2(MAX_PTS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_PT  = c_CNT_W'(MAX_PTS - 1);
  localparam int                 c_END_BIT  = 2*DAC_WIDTH + 1;
  localparam int                 c_BEAM_BIT = 2*DAC_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                   r_state;
  logic [2:0]               r_spawn;
  logic [DAC_WIDTH-1:0]     r_x1, r_x2, r_x3;
  logic [ADDRESSWIDTH-1:0]  r_adr1, r_adr2, r_adr3;
  // Enemy index 1..3; 0 means the index has stepped past enemy 3.
  logic [1:0]               r_idx;
  logic [c_CNT_W-1:0]       r_count;
  logic                     r_end;

  logic                     w_sel_spawn;
  logic [DAC_WIDTH-1:0]     w_sel_x;
  logic [DAC_WIDTH-1:0]     w_sel_y;
  logic [ADDRESSWIDTH-1:0]  w_sel_adr;
  logic [DAC_WIDTH:0]       w_sum_x;
  logic [DAC_WIDTH:0]       w_sum_y;
  logic                     w_last_pt;

  always_comb begin
    w_sel_spawn = 1'b0;
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_adr   = '0;
    case (r_idx)
      2'd1: begin
        w_sel_spawn = r_spawn[0];
        w_sel_x     = r_x1;
        w_sel_y     = Y_ENEMY1;
        w_sel_adr   = r_adr1;
      end
      2'd2: begin
        w_sel_spawn = r_spawn[1];
        w_sel_x     = r_x2;
        w_sel_y     = Y_ENEMY2;
        w_sel_adr   = r_adr2;
      end
      2'd3: begin
        w_sel_spawn = r_spawn[2];
        w_sel_x     = r_x3;
        w_sel_y     = Y_ENEMY3;
        w_sel_adr   = r_adr3;
      end
      default: ;
    endcase
  end

  // One extra bit catches the carry so the sum can clamp to full scale.
  assign w_sum_x   = {1'b0, w_sel_x} + {1'b0, rom_data[2*DAC_WIDTH-1:DAC_WIDTH]};
  assign w_sum_y   = {1'b0, w_sel_y} + {1'b0, rom_data[DAC_WIDTH-1:0]};
  assign w_last_pt = r_end || (r_count == c_LAST_PT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_spawn    <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_x3       <= '0;
      r_adr1     <= '0;
      r_adr2     <= '0;
      r_adr3     <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_end      <= 1'b0;
      rom_adr    <= '0;
      pt_x       <= '0;
      pt_y       <= '0;
      pt_beam    <= 1'b0;
      pt_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_spawn <= {spawn_enemy3, spawn_enemy2, spawn_enemy1};
            r_x1    <= xenemy1;
            r_x2    <= xenemy2;
            r_x3    <= xenemy3;
            r_adr1  <= adr_enemy1;
            r_adr2  <= adr_enemy2;
            r_adr3  <= adr_enemy3;
            r_idx   <= 2'd1;
            busy    <= 1'b1;
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_idx == 2'd0) begin
            r_state <= S_DONE;
          end else if (w_sel_spawn) begin
            rom_adr <= w_sel_adr;
            r_count <= '0;
            r_state <= S_FETCH;
          end else if (r_idx == 2'd3) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        // ROM samples rom_adr at the end of this cycle.
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_end    <= rom_data[c_END_BIT];
          pt_x     <= w_sum_x[DAC_WIDTH] ? {DAC_WIDTH{1'b1}} : w_sum_x[DAC_WIDTH-1:0];
          pt_y     <= w_sum_y[DAC_WIDTH] ? {DAC_WIDTH{1'b1}} : w_sum_y[DAC_WIDTH-1:0];
          pt_beam  <= rom_data[c_BEAM_BIT];
          pt_valid <= 1'b1;
          r_state  <= S_EMIT;
        end
        S_EMIT: begin
          if (pt_ready) begin
            pt_valid <= 1'b0;
            if (w_last_pt) begin
              // Index 3 wraps to 0, which SELECT treats as "all enemies done".
              r_idx   <= r_idx + 2'd1;
              r_state <= S_SELECT;
            end else begin
              rom_adr <= rom_adr + ADDRESSWIDTH'(1);
              r_count <= r_count + c_CNT_W'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enemy_vector_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_vector_renderer
// Purpose  : Self-checking bench for enemy_vector_renderer. A behavioural
//            model expands each enemy snapshot into the list of expected
//            beam points straight from the ROM contents, and the observed
//            point stream is compared against it.
// Revision : 1.0  initial release
// ============================================================================
module tb_enemy_vector_renderer;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int MAXP = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          spawn_enemy1, spawn_enemy2, spawn_enemy3;
  logic [DW-1:0] xenemy1, xenemy2, xenemy3;
  logic [AW-1:0] adr_enemy1, adr_enemy2, adr_enemy3;
  logic [AW-1:0] rom_adr;
  logic [2*DW+1:0] rom_data;
  logic [DW-1:0] pt_x, pt_y;
  logic          pt_beam, pt_valid, pt_ready, busy, frame_done;

  always #5 clk = ~clk;

  enemy_vector_renderer #(
    .DAC_WIDTH(DW), .ADDRESSWIDTH(AW),
    .Y_ENEMY1(8'd200), .Y_ENEMY2(8'd150), .Y_ENEMY3(8'd100), .MAX_PTS(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .spawn_enemy1(spawn_enemy1), .spawn_enemy2(spawn_enemy2), .spawn_enemy3(spawn_enemy3),
    .xenemy1(xenemy1), .xenemy2(xenemy2), .xenemy3(xenemy3),
    .adr_enemy1(adr_enemy1), .adr_enemy2(adr_enemy2), .adr_enemy3(adr_enemy3),
    .rom_adr(rom_adr), .rom_data(rom_data),
    .pt_x(pt_x), .pt_y(pt_y), .pt_beam(pt_beam), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .busy(busy), .frame_done(frame_done)
  );

  // Image ROM: {end, beam_on, x_off, y_off}, one cycle read latency.
  logic [17:0] rom [0:65535];
  always @(posedge clk) rom_data <= rom[rom_adr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          ylane [3] = '{200, 150, 100};
  logic        s_spawn [3];
  logic [7:0]  s_x [3];
  logic [15:0] s_adr [3];
  logic [16:0] exp_q [$];
  int          n_exp;

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : v[7:0];
  endfunction

  task automatic build_expected();
    logic [15:0] a;
    logic [17:0] d;
    exp_q.delete();
    for (int e = 0; e < 3; e++) begin
      if (s_spawn[e]) begin
        a = s_adr[e];
        for (int n = 0; n < MAXP; n++) begin
          d = rom[a];
          exp_q.push_back({sat8(int'(s_x[e]) + int'(d[15:8])),
                           sat8(ylane[e] + int'(d[7:0])), d[16]});
          if (d[17]) break;
          a = a + 16'd1;
        end
      end
    end
    n_exp = exp_q.size();
  endtask

  // ---------------- per-cycle monitor/driver ----------------
  int          cyc = 0;
  int          ready_mode = 0;
  int          hold_cnt;
  int          npts;
  int          nframe_done;
  int          first_valid_cyc;
  int          done_cyc;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_pt;
  logic [15:0] prev_adr;

  task automatic tick();
    @(negedge clk);
    cyc++;
    case (ready_mode)
      0: pt_ready = 1'b1;
      1: pt_ready = 1'($urandom_range(0, 1));
      2: begin
        if (pt_valid && hold_cnt < 7) begin
          pt_ready = 1'b0;
          hold_cnt++;
        end else begin
          pt_ready = 1'b1;
        end
      end
      default: pt_ready = 1'b0;
    endcase
    if (prev_stall) begin
      chk("hold_valid", 32'(pt_valid), 32'd1);
      chk("hold_point", 32'({pt_x, pt_y, pt_beam}), 32'(prev_pt));
      chk("hold_adr", 32'(rom_adr), 32'(prev_adr));
    end
    if (pt_valid && pt_ready) begin
      if (exp_q.size() == 0) chk("point_count", npts + 1, n_exp);
      else chk("point", 32'({pt_x, pt_y, pt_beam}), 32'(exp_q.pop_front()));
      npts++;
    end
    if (pt_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (frame_done) begin
      nframe_done++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    prev_stall = pt_valid && !pt_ready && rst_n;
    prev_pt    = {pt_x, pt_y, pt_beam};
    prev_adr   = rom_adr;
  endtask

  task automatic scramble_inputs();
    spawn_enemy1 = 1'($urandom); spawn_enemy2 = 1'($urandom); spawn_enemy3 = 1'($urandom);
    xenemy1 = 8'($urandom); xenemy2 = 8'($urandom); xenemy3 = 8'($urandom);
    adr_enemy1 = 16'($urandom); adr_enemy2 = 16'($urandom); adr_enemy3 = 16'($urandom);
  endtask

  task automatic reset_counters();
    hold_cnt = 0; npts = 0; nframe_done = 0; first_valid_cyc = -1; done_cyc = -1;
  endtask

  task automatic run_pass(input int mode, input bit poke);
    int start_cyc;
    build_expected();
    ready_mode = mode;
    reset_counters();
    tick();
    frame_start = 1'b1;
    spawn_enemy1 = s_spawn[0]; spawn_enemy2 = s_spawn[1]; spawn_enemy3 = s_spawn[2];
    xenemy1 = s_x[0]; xenemy2 = s_x[1]; xenemy3 = s_x[2];
    adr_enemy1 = s_adr[0]; adr_enemy2 = s_adr[1]; adr_enemy3 = s_adr[2];
    start_cyc = cyc;
    tick();
    frame_start = 1'b0;
    scramble_inputs();
    chk("busy_set", 32'(busy), 32'd1);
    while (nframe_done == 0 && (cyc - start_cyc) < 3000) begin
      tick();
      frame_start = poke && (cyc == start_cyc + 3);
    end
    frame_start = 1'b0;
    chk("frame_done_seen", nframe_done, 1);
    if (s_spawn[0]) chk("first_valid_lat", first_valid_cyc - start_cyc, 4);
    if (!(s_spawn[0] || s_spawn[1] || s_spawn[2])) begin
      chk("done_lat", done_cyc - start_cyc, 5);
      chk("no_points", npts, 0);
    end
    repeat (8) tick();
    chk("single_done", nframe_done, 1);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("points_left", exp_q.size(), 0);
  endtask

  task automatic set_snap(input logic sp1, sp2, sp3, input logic [7:0] x1, x2, x3,
                          input logic [15:0] a1, a2, a3);
    s_spawn[0] = sp1; s_spawn[1] = sp2; s_spawn[2] = sp3;
    s_x[0] = x1; s_x[1] = x2; s_x[2] = x3;
    s_adr[0] = a1; s_adr[1] = a2; s_adr[2] = a3;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 65536; i++) rom[i] = {($urandom_range(0, 3) == 0), 17'($urandom)};
    // Directed sprites
    rom[16'h0100] = {1'b0, 1'b1, 8'd5, 8'd3};
    rom[16'h0101] = {1'b1, 1'b0, 8'd2, 8'd2};
    rom[16'h0010] = {1'b1, 1'b1, 8'd1, 8'd2};
    rom[16'h0020] = {1'b1, 1'b0, 8'd3, 8'd4};
    rom[16'h0030] = {1'b1, 1'b1, 8'd5, 8'd6};
    rom[16'h0300] = {1'b1, 1'b1, 8'd20, 8'd60};
    for (int i = 16'h0400; i < 16'h0450; i++) rom[i] = {1'b0, 1'b1, 8'(i), 8'(i >> 1)};
    rom[16'hFFFF] = {1'b0, 1'b1, 8'd7, 8'd9};
    rom[16'h0000] = {1'b1, 1'b0, 8'd1, 8'd1};

    // Reset with frame_start held high
    rst_n = 1'b0; frame_start = 1'b1; pt_ready = 1'b0;
    scramble_inputs();
    reset_counters();
    n_exp = 0;
    repeat (3) begin
      tick();
      chk("reset_outputs", 32'({rom_adr, pt_x, pt_y, pt_beam, pt_valid, busy, frame_done}), 32'd0);
    end
    rst_n = 1'b1; frame_start = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single enemy, two points
    set_snap(1, 0, 0, 8'd10, 8'd0, 8'd0, 16'h0100, 16'h0, 16'h0);
    run_pass(0, 0);
    chk("single_pts", npts, 2);

    // All three spawned, one point each, enemy order
    set_snap(1, 1, 1, 8'd50, 8'd60, 8'd70, 16'h0010, 16'h0020, 16'h0030);
    run_pass(0, 0);
    chk("three_pts", npts, 3);

    // Backpressure on first point
    set_snap(1, 0, 0, 8'd10, 8'd0, 8'd0, 16'h0100, 16'h0, 16'h0);
    run_pass(2, 0);
    chk("bp_stalls", hold_cnt, 7);

    // Saturation
    set_snap(1, 0, 0, 8'd250, 8'd0, 8'd0, 16'h0300, 16'h0, 16'h0);
    run_pass(0, 0);

    // Missing end flag guard, then next enemy
    set_snap(1, 1, 0, 8'd3, 8'd9, 8'd0, 16'h0400, 16'h0010, 16'h0);
    run_pass(1, 0);
    chk("guard_pts", npts, 65);

    // Address wrap on enemy 3
    set_snap(0, 0, 1, 8'd0, 8'd0, 8'd40, 16'h0, 16'h0, 16'hFFFF);
    run_pass(0, 0);
    chk("wrap_pts", npts, 2);

    // None spawned, frame_start poked mid-pass
    set_snap(0, 0, 0, 8'd1, 8'd2, 8'd3, 16'h0100, 16'h0200, 16'h0300);
    run_pass(0, 1);

    // Random passes
    for (int p = 0; p < 25; p++) begin
      set_snap(1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom));
      run_pass(1, 1'($urandom));
    end

    // Reset while a point is waiting in EMIT
    set_snap(1, 0, 0, 8'd10, 8'd0, 8'd0, 16'h0100, 16'h0, 16'h0);
    build_expected();
    ready_mode = 3;
    reset_counters();
    tick();
    frame_start = 1'b1;
    spawn_enemy1 = 1'b1; xenemy1 = 8'd10; adr_enemy1 = 16'h0100;
    spawn_enemy2 = 1'b0; spawn_enemy3 = 1'b0;
    tick();
    frame_start = 1'b0;
    k = 0;
    while (!pt_valid && k < 20) begin
      tick();
      k++;
    end
    chk("reach_emit", 32'(pt_valid), 32'd1);
    rst_n = 1'b0;
    prev_stall = 1'b0;
    tick();
    chk("rst_valid", 32'(pt_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    ready_mode = 0;
    exp_q.delete();
    nframe_done = 0;
    repeat (10) tick();
    chk("no_done_abort", nframe_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
